detector_jogada: RTL and testbench

- Upstream input stage for the compare datapath: conditions four raw push-buttons and emits one clean, registered 4-bit play plus a one-cycle strobe.
- Output feeds the datapath switch input (`chaves`); strobe feeds the control unit as the "play made" event.
- Per button: 2-FF synchronization, stability-counter debounce, one-hot validity check, mandatory full-release before the next play.

---
 rtl/detector_jogada_pkg.sv | 8 +
 rtl/detector_jogada_sincronizador.sv | 14 +
 rtl/detector_jogada.sv | 73 +++++++
 tb/tb_detector_jogada.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/detector_jogada_pkg.sv
// detector_jogada_pkg: state codes shared with the other debug displays
package detector_jogada_pkg;
  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    FILTRA        = 4'd1,
    ESPERA_SOLTAR = 4'd2
  } estado_t;
endpackage

// File: rtl/detector_jogada_sincronizador.sv
// sincronizador_2ff: two-flop synchronizer for asynchronous level inputs
module sincronizador_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clock or negedge reset)
    if (!reset) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/detector_jogada.sv
// detector_jogada: debounces push-buttons into one registered one-hot play plus strobes
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] botoes,
  input  logic             habilita,
  input  logic             limpa,
  output logic [WIDTH-1:0] jogada,
  output logic             jogada_feita,
  output logic             jogada_invalida,
  output logic [3:0]       db_estado
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  estado_t          estado;
  logic [WIDTH-1:0] sinc, candidato;
  logic [CW-1:0]    cnt;
  function automatic logic one_hot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction
  sincronizador_2ff #(.WIDTH(WIDTH)) u_sinc (
    .clock(clock),
    .reset(reset),
    .d    (botoes),
    .q    (sinc)
  );
  assign db_estado = estado;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado          <= OCIOSO;
      candidato       <= '0;
      cnt             <= '0;
      jogada          <= '0;
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
    end else begin
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
      if (limpa) jogada <= '0;
      case (estado)
        OCIOSO:
          if (habilita && sinc != '0) begin
            candidato <= sinc;
            cnt       <= '0;
            estado    <= FILTRA;
          end
        FILTRA:
          if (!habilita || sinc != candidato) begin
            cnt    <= '0;
            estado <= OCIOSO;
          end else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          else begin
            // release filter starts from zero even if the button lifts right at acceptance
            cnt    <= '0;
            estado <= ESPERA_SOLTAR;
            if (one_hot(candidato)) begin
              jogada       <= candidato;
              jogada_feita <= 1'b1;
            end else jogada_invalida <= 1'b1;
          end
        ESPERA_SOLTAR:
          if (sinc != '0) cnt <= '0;
          else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          else estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: scoreboard bench; expected strobes queued at stimulus, matched at output
module tb_detector_jogada;
  typedef struct {logic inval; logic [3:0] jog; int ciclo;} exp_t;
  logic       clock = 1'b0, reset = 1'b0, habilita = 1'b0, limpa = 1'b0;
  logic [3:0] botoes = '0, jogada, db_estado;
  logic       jogada_feita, jogada_invalida;
  int         checks = 0, errors = 0, ciclo = 0;
  exp_t       fila[$];

  detector_jogada #(.WIDTH(4), .DEBOUNCE_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .botoes(botoes), .habilita(habilita), .limpa(limpa),
    .jogada(jogada), .jogada_feita(jogada_feita), .jogada_invalida(jogada_invalida),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ciclo <= ciclo + 1;

  always @(negedge clock)
    if (jogada_feita || jogada_invalida) begin
      checks++;
      if (fila.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected ciclo=%0d feita=%b inval=%b jogada=%b", ciclo, jogada_feita, jogada_invalida, jogada);
      end else begin
        exp_t e;
        e = fila.pop_front();
        if ({jogada_feita, jogada_invalida, jogada, ciclo} !== {!e.inval, e.inval, e.jog, e.ciclo}) begin
          errors++;
          $display("FAIL strobe_match got feita=%b inval=%b jogada=%b ciclo=%0d exp feita=%b inval=%b jogada=%b ciclo=%0d",
                   jogada_feita, jogada_invalida, jogada, ciclo, !e.inval, e.inval, e.jog, e.ciclo);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL timeout ciclo=%0d", ciclo);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 0; botoes = 4'b0100; habilita = 1;
    tick(3);
    checks++;
    if ({jogada, jogada_feita, jogada_invalida, db_estado} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {jogada, jogada_feita, jogada_invalida, db_estado});
    end
    reset = 1;
    fila.push_back('{1'b0, 4'b0100, ciclo + 19});
    tick(2);
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_idle got=%0d exp=0", db_estado); end
    tick(1);
    checks++;
    if (db_estado !== 4'd1) begin errors++; $display("FAIL reset_filtra got=%0d exp=1", db_estado); end
    tick(25); botoes = 0; tick(20);
    checks++;
    if (fila.size() != 0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", fila.size()); fila.delete(); end
  endtask

  task automatic test_clean_press;
    botoes = 4'b0100;
    fila.push_back('{1'b0, 4'b0100, ciclo + 19});
    tick(18);
    checks++;
    if (db_estado !== 4'd1 || jogada_feita !== 1'b0) begin
      errors++; $display("FAIL press_pre got estado=%0d feita=%b exp estado=1 feita=0", db_estado, jogada_feita);
    end
    tick(1);
    checks++;
    if ({jogada_feita, jogada, db_estado} !== {1'b1, 4'b0100, 4'd2}) begin
      errors++; $display("FAIL press_accept got feita=%b jogada=%b estado=%0d exp 1 0100 2", jogada_feita, jogada, db_estado);
    end
    tick(1);
    checks++;
    if (jogada_feita !== 1'b0) begin errors++; $display("FAIL press_one_cycle got=%b exp=0", jogada_feita); end
    tick(20);
    botoes = 0;
    tick(17);
    checks++;
    if (db_estado !== 4'd2) begin errors++; $display("FAIL release_hold got=%0d exp=2", db_estado); end
    tick(1);
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL release_idle got=%0d exp=0", db_estado); end
    checks++;
    if (fila.size() != 0) begin errors++; $display("FAIL press_pending got=%0d exp=0", fila.size()); fila.delete(); end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 6; i++) begin
      botoes = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      tick(5);
    end
    botoes = 4'b0100;
    fila.push_back('{1'b0, 4'b0100, ciclo + 19});
    tick(25); botoes = 0; tick(20);
    checks++;
    if (fila.size() != 0) begin errors++; $display("FAIL bounce_pending got=%0d exp=0", fila.size()); fila.delete(); end
  endtask

  task automatic test_multi;
    botoes = 4'b0010;
    fila.push_back('{1'b0, 4'b0010, ciclo + 19});
    tick(22); botoes = 0; tick(20);
    botoes = 4'b0101;
    fila.push_back('{1'b1, 4'b0010, ciclo + 19});
    tick(30);
    checks++;
    if (jogada !== 4'b0010 || db_estado !== 4'd2) begin
      errors++; $display("FAIL multi_hold got jogada=%b estado=%0d exp 0010 2", jogada, db_estado);
    end
    botoes = 0; tick(20);
    checks++;
    if (fila.size() != 0) begin errors++; $display("FAIL multi_pending got=%0d exp=0", fila.size()); fila.delete(); end
  endtask

  task automatic test_enable;
    habilita = 0; botoes = 4'b1000;
    tick(30);
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL enable_off got=%0d exp=0", db_estado); end
    botoes = 0; tick(5); habilita = 1;
    botoes = 4'b1000;
    tick(13);
    checks++;
    if (db_estado !== 4'd1) begin errors++; $display("FAIL enable_filtra got=%0d exp=1", db_estado); end
    habilita = 0;
    tick(1);
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL enable_drop got=%0d exp=0", db_estado); end
    tick(20); botoes = 0; tick(5); habilita = 1;
    checks++;
    if (jogada !== 4'b0010) begin errors++; $display("FAIL enable_jogada got=%b exp=0010", jogada); end
  endtask

  task automatic test_clear;
    botoes = 4'b0001;
    fila.push_back('{1'b0, 4'b0001, ciclo + 19});
    tick(20);
    limpa = 1; tick(1); limpa = 0;
    checks++;
    if (jogada !== 4'b0000 || db_estado !== 4'd2) begin
      errors++; $display("FAIL clear got jogada=%b estado=%0d exp 0000 2", jogada, db_estado);
    end
    botoes = 0; tick(20);
    botoes = 4'b1000;
    fila.push_back('{1'b0, 4'b1000, ciclo + 19});
    tick(18);
    limpa = 1; tick(1); limpa = 0;
    checks++;
    if (jogada !== 4'b1000) begin errors++; $display("FAIL clear_vs_accept got=%b exp=1000", jogada); end
    tick(5); botoes = 0; tick(20);
    checks++;
    if (fila.size() != 0) begin errors++; $display("FAIL clear_pending got=%0d exp=0", fila.size()); fila.delete(); end
  endtask

  task automatic test_reset_mid;
    botoes = 4'b0100;
    tick(10);
    reset = 0; #1;
    checks++;
    if ({jogada, jogada_feita, jogada_invalida, db_estado} !== 10'b0) begin
      errors++; $display("FAIL reset_mid got=%b exp=0", {jogada, jogada_feita, jogada_invalida, db_estado});
    end
    tick(2);
    reset = 1;
    fila.push_back('{1'b0, 4'b0100, ciclo + 19});
    tick(25); botoes = 0; tick(20);
    checks++;
    if (fila.size() != 0) begin errors++; $display("FAIL reset_mid_pending got=%0d exp=0", fila.size()); fila.delete(); end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_multi;
    test_enable;
    test_clear;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
